mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port data memory access FSM for the MEM stage.
// Issues one request per load/store. It stalls the pipeline until the memory
// acknowledges or the wait times out. Misaligned addresses never reach memory.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   aluResultIN         byte address from EX/MEM
//   writeDataIN         store data from EX/MEM
//   MemWriteIN          store request from EX/MEM
//   ResultSrcIN         2'b01 marks a load
//   memReq/memWe        memory request strobe and write enable (registered)
//   memAddr/memWdata    request address and store data (registered)
//   memAck/memRdata     memory completion and load data
//   readDataOUT         last load result, to MEM/WB (registered)
//   stallM              combinational freeze of EX/MEM and upstream
//   busErr/alignErr     sticky timeout and misalignment flags (reset-only clear)
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluResultIN,
  input  logic [31:0] writeDataIN,
  input  logic        MemWriteIN,
  input  logic [1:0]  ResultSrcIN,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic [31:0] readDataOUT,
  output logic        stallM,
  output logic        busErr,
  output logic        alignErr
);

  localparam logic [7:0] L_WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_memReq;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [31:0] r_readData;
  logic [7:0]  r_waitCnt;
  logic        r_busErr;
  logic        r_alignErr;

  logic w_access;
  logic w_aligned;

  assign w_access  = MemWriteIN | (ResultSrcIN == 2'b01);
  assign w_aligned = (aluResultIN[1:0] == 2'b00);

  // Stall is held low during reset so the pipeline is never frozen by stale inputs.
  assign stallM = ~reset & (((r_state == IDLE) & w_access) | (r_state == BUSY));

  // Access FSM with registered memory-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 32'h0;
      r_memWdata <= 32'h0;
      r_readData <= 32'h0;
      r_waitCnt  <= 8'h0;
      r_busErr   <= 1'b0;
      r_alignErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_aligned) begin
              r_state    <= BUSY;
              r_memReq   <= 1'b1;
              r_memWe    <= MemWriteIN;
              r_memAddr  <= aluResultIN;
              r_memWdata <= writeDataIN;
              r_waitCnt  <= 8'h0;
            end else begin
              r_state    <= DONE;
              r_alignErr <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ack takes priority over the timeout on the same cycle.
          if (memAck) begin
            r_state  <= DONE;
            r_memReq <= 1'b0;
            if (!r_memWe) begin
              r_readData <= memRdata;
            end
          end else if (r_waitCnt == L_WAIT_LAST) begin
            r_state  <= DONE;
            r_memReq <= 1'b0;
            r_busErr <= 1'b1;
            if (!r_memWe) begin
              r_readData <= 32'h0;
            end
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

  assign memReq      = r_memReq;
  assign memWe       = r_memWe;
  assign memAddr     = r_memAddr;
  assign memWdata    = r_memWdata;
  assign readDataOUT = r_readData;
  assign busErr      = r_busErr;
  assign alignErr    = r_alignErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus hand sequences for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] aluResultIN;
  logic [31:0] writeDataIN;
  logic        MemWriteIN;
  logic [1:0]  ResultSrcIN;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memAck;
  logic [31:0] memRdata;
  logic [31:0] readDataOUT;
  logic        stallM;
  logic        busErr;
  logic        alignErr;

  int n_pass  = 0;
  int n_total = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .aluResultIN(aluResultIN),
    .writeDataIN(writeDataIN),
    .MemWriteIN (MemWriteIN),
    .ResultSrcIN(ResultSrcIN),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memAck     (memAck),
    .memRdata   (memRdata),
    .readDataOUT(readDataOUT),
    .stallM     (stallM),
    .busErr     (busErr),
    .alignErr   (alignErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rdat;
    logic        e_stall;  // before the edge
    logic        e_req;    // after the edge from here on
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_be;
    logic        e_ae;
  } vec_t;

  localparam int N_VEC = 17;
  vec_t vecs [N_VEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic setin(input logic mw, input logic [1:0] rs, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
    MemWriteIN  = mw;
    ResultSrcIN = rs;
    aluResultIN = addr;
    writeDataIN = wd;
    memAck      = ack;
    memRdata    = rdat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load with ack on first BUSY cycle, then an ack in IDLE that must be ignored.
    vecs[0]  = '{1'b0, 2'b01, 32'h100, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 32'h100, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0,   32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    // Store acknowledged after three BUSY cycles.
    vecs[4]  = '{1'b1, 2'b00, 32'h20, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 32'h20, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 32'h20, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 32'h20, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0};
    // Back-to-back loads; ack during DONE ignored.
    vecs[9]  = '{1'b0, 2'b01, 32'h200, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 32'h200, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'b01, 32'h204, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 32'h204, 32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 32'h204, 32'h0, 1'b1, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0};
    // Misaligned load: no request, one stall cycle, sticky alignErr.
    vecs[15] = '{1'b0, 2'b01, 32'h102, 32'h0, 1'b1, 32'h77777777, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b1};

    // Reset state, with a load presented to confirm stallM is masked.
    reset = 1'b1;
    setin(1'b0, 2'b01, 32'h100, 32'h0, 1'b0, 32'h0);
    #2;
    chk("rst_stall", 32'(stallM), 32'h0);
    chk("rst_req",   32'(memReq), 32'h0);
    chk("rst_we",    32'(memWe), 32'h0);
    chk("rst_addr",  memAddr, 32'h0);
    chk("rst_wdata", memWdata, 32'h0);
    chk("rst_rdata", readDataOUT, 32'h0);
    chk("rst_errs",  32'({busErr, alignErr}), 32'h0);
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    reset = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      setin(vecs[i].mw, vecs[i].rs, vecs[i].addr, vecs[i].wd, vecs[i].ack, vecs[i].rdat);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stallM), 32'(vecs[i].e_stall));
      step();
      chk($sformatf("v%0d_req", i),   32'(memReq), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i),    32'(memWe), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i),  memAddr, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), memWdata, vecs[i].e_wd);
      chk($sformatf("v%0d_rdata", i), readDataOUT, vecs[i].e_rd);
      chk($sformatf("v%0d_busErr", i), 32'(busErr), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_alignErr", i), 32'(alignErr), 32'(vecs[i].e_ae));
    end

    // Ack arriving on the same cycle as the timeout: ack wins.
    setin(1'b0, 2'b01, 32'h300, 32'h0, 1'b0, 32'h0);
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("race_busy%0d_req", k), 32'(memReq), 32'h1);
    end
    setin(1'b0, 2'b01, 32'h300, 32'h0, 1'b1, 32'h13579BDF);
    step();
    chk("race_req",    32'(memReq), 32'h0);
    chk("race_rdata",  readDataOUT, 32'h13579BDF);
    chk("race_busErr", 32'(busErr), 32'h0);
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // Timeout: 16 BUSY cycles, then DONE with busErr and zeroed load data.
    setin(1'b0, 2'b01, 32'h304, 32'h0, 1'b0, 32'h0);
    step();
    chk("to_enter_req", 32'(memReq), 32'h1);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("to_busy%0d", k), 32'({memReq, busErr}), 32'h2);
    end
    step();
    chk("to_req",    32'(memReq), 32'h0);
    chk("to_busErr", 32'(busErr), 32'h1);
    chk("to_rdata",  readDataOUT, 32'h0);
    chk("to_stall",  32'(stallM), 32'h0);
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // busErr stays set across a later successful store.
    setin(1'b1, 2'b00, 32'h40, 32'h55AA55AA, 1'b0, 32'h0);
    step();
    setin(1'b1, 2'b00, 32'h40, 32'h55AA55AA, 1'b1, 32'h99999999);
    step();
    chk("sticky_req",    32'(memReq), 32'h0);
    chk("sticky_busErr", 32'(busErr), 32'h1);
    chk("sticky_rdata",  readDataOUT, 32'h0);
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // Reset on the second BUSY cycle, then a late ack.
    setin(1'b0, 2'b01, 32'h400, 32'h0, 1'b0, 32'h0);
    step();
    step();
    chk("mid_busy_req", 32'(memReq), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_req",   32'(memReq), 32'h0);
    chk("mid_rst_stall", 32'(stallM), 32'h0);
    chk("mid_rst_errs",  32'({busErr, alignErr}), 32'h0);
    chk("mid_rst_addr",  memAddr, 32'h0);
    #1;
    reset = 1'b0;
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    #1;
    chk("post_rst_stall", 32'(stallM), 32'h0);
    step();
    chk("late_ack_rdata", readDataOUT, 32'h0);
    chk("late_ack_req",   32'(memReq), 32'h0);
    setin(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
